// File: rtl/regex_mem_arbiter_if.sv
// regex_mem_arbiter_if
//   Fetch and host-program handshake bundle of the instruction memory arbiter.
//   cpu_mem_valid / cpu_mem_addr : per-CPU fetch request and address (slice i at [i*AW +: AW])
//   cpu_mem_ready / cpu_mem_data : one-hot grant pulse and broadcast fetched word
//   prog_valid / prog_addr / prog_data / prog_ready : host program-write handshake
//   slave modport: arbiter side; master modport: requester side.
interface regex_mem_arbiter_if #(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11
);
  logic [N_CPU-1:0]                   cpu_mem_valid;
  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0] cpu_mem_addr;
  logic [N_CPU-1:0]                   cpu_mem_ready;
  logic [MEMORY_WIDTH-1:0]            cpu_mem_data;
  logic                               prog_valid;
  logic [MEMORY_ADDR_WIDTH-1:0]       prog_addr;
  logic [MEMORY_WIDTH-1:0]            prog_data;
  logic                               prog_ready;

  modport slave (
    input  cpu_mem_valid, cpu_mem_addr, prog_valid, prog_addr, prog_data,
    output cpu_mem_ready, cpu_mem_data, prog_ready
  );

  modport master (
    output cpu_mem_valid, cpu_mem_addr, prog_valid, prog_addr, prog_data,
    input  cpu_mem_ready, cpu_mem_data, prog_ready
  );
endinterface

// File: rtl/regex_mem_arbiter.sv
// regex_mem_arbiter
//   Shares one instruction BRAM between N_CPU regex_cpu fetch ports and a
//   host program-write port. Host writes win over fetches; fetches are served
//   round-robin, one BRAM access per transaction (fetch 3 cycles, write 2).
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : fetch/program handshakes (regex_mem_arbiter_if.slave)
//   cfg_hold   : blocks new CPU grants, host writes still served
//   bram_*     : BRAM port (read data valid one cycle after a read enable)
//   read_count / write_count : saturating served-access counters
module regex_mem_arbiter #(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  regex_mem_arbiter_if.slave           bus,
  input  logic                         cfg_hold,
  output logic                         bram_en,
  output logic                         bram_we,
  output logic [MEMORY_ADDR_WIDTH-1:0] bram_addr,
  output logic [MEMORY_WIDTH-1:0]      bram_wdata,
  input  logic [MEMORY_WIDTH-1:0]      bram_rdata,
  output logic [CNT_WIDTH-1:0]         read_count,
  output logic [CNT_WIDTH-1:0]         write_count
);
  localparam int IW = (N_CPU > 1) ? $clog2(N_CPU) : 1;

  typedef enum logic [1:0] {IDLE, READ, RESP, WRITE} state_t;

  state_t                       state, state_nx;
  logic [IW-1:0]                rr_ptr;
  logic [IW-1:0]                g_q;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_q;
  logic [MEMORY_WIDTH-1:0]      wdata_q;
  logic [MEMORY_WIDTH-1:0]      data_q;

  logic                         win_found;
  logic [IW-1:0]                win_idx;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_arr [N_CPU];

  for (genvar i = 0; i < N_CPU; i++) begin : g_addr
    assign addr_arr[i] = bus.cpu_mem_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
  end

  // First valid requester searching rr_ptr, rr_ptr+1, ... with wrap.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N_CPU; k++) begin
      cand = (32'(rr_ptr) + k) % N_CPU;
      if (!win_found && bus.cpu_mem_valid[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_nx          = state;
    bram_en           = 1'b0;
    bram_we           = 1'b0;
    bram_addr         = '0;
    bram_wdata        = '0;
    bus.cpu_mem_ready = '0;
    bus.prog_ready    = 1'b0;
    bus.cpu_mem_data  = data_q;
    case (state)
      IDLE: begin
        if (bus.prog_valid)
          state_nx = WRITE;
        else if (win_found && !cfg_hold)
          state_nx = READ;
      end
      READ: begin
        bram_en                = 1'b1;
        bram_addr              = addr_q;
        bus.cpu_mem_ready[g_q] = 1'b1;
        state_nx               = RESP;
      end
      RESP: begin
        bus.cpu_mem_data = bram_rdata;
        state_nx         = IDLE;
      end
      WRITE: begin
        bram_en        = 1'b1;
        bram_we        = 1'b1;
        bram_addr      = addr_q;
        bram_wdata     = wdata_q;
        bus.prog_ready = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      g_q         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.prog_valid) begin
            addr_q  <= bus.prog_addr;
            wdata_q <= bus.prog_data;
          end else if (win_found && !cfg_hold) begin
            g_q    <= win_idx;
            addr_q <= addr_arr[win_idx];
          end
        end
        RESP: begin
          data_q <= bram_rdata;
          rr_ptr <= (g_q == IW'(N_CPU - 1)) ? '0 : g_q + 1'b1;
          if (read_count != '1)
            read_count <= read_count + 1'b1;
        end
        WRITE: begin
          if (write_count != '1)
            write_count <= write_count + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/regex_mem_arbiter.md
REGEX_MEM_ARBITER -- requirements
Module: regex_mem_arbiter

Interface
REQ-001 SHALL have parameter N_CPU, default 4, number of regex_cpu fetch requesters (2..8).
REQ-002 SHALL have parameter MEMORY_WIDTH, default 20, instruction word width.
REQ-003 SHALL have parameter MEMORY_ADDR_WIDTH, default 11, instruction address width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 cpu_mem_valid  in  N_CPU  per-CPU fetch request, held until served.
REQ-008 cpu_mem_addr  in  N_CPU*MEMORY_ADDR_WIDTH  per-CPU fetch address; slice i at [i*AW +: AW].
REQ-009 cpu_mem_ready  out  N_CPU  one-hot, one-cycle grant pulse to the served CPU.
REQ-010 cpu_mem_data  out  MEMORY_WIDTH  fetched word, broadcast to all CPUs.
REQ-011 prog_valid  in  1  host program-write request, held until prog_ready.
REQ-012 prog_addr  in  MEMORY_ADDR_WIDTH  host write address.
REQ-013 prog_data  in  MEMORY_WIDTH  host write data.
REQ-014 prog_ready  out  1  one-cycle pulse; host write performed this cycle.
REQ-015 cfg_hold  in  1  when 1, no new CPU grants; host writes still served.
REQ-016 bram_en, bram_we  out  1 each  BRAM enable, write enable.
REQ-017 bram_addr  out  MEMORY_ADDR_WIDTH; bram_wdata  out  MEMORY_WIDTH.
REQ-018 bram_rdata  in  MEMORY_WIDTH  read data, valid exactly one cycle after bram_en with bram_we=0.
REQ-019 read_count, write_count  out  CNT_WIDTH each  served reads / writes.

Function
REQ-020 SHALL implement FSM states IDLE, READ, RESP, WRITE.
REQ-021 IDLE: prog_valid=1 -> latch prog_addr/prog_data, go WRITE; else any cpu_mem_valid=1 and cfg_hold=0 -> latch winner index g and its address, go READ; else stay.
REQ-022 Host write SHALL have absolute priority over CPU fetches when both sampled in the same IDLE cycle.
REQ-023 Winner SHALL be the first requester with valid=1 searching rr_ptr, rr_ptr+1, ... modulo N_CPU.
REQ-024 READ (1 cycle): bram_en=1, bram_we=0, bram_addr=latched address, cpu_mem_ready[g]=1; next RESP.
REQ-025 RESP (1 cycle): cpu_mem_data=bram_rdata; data_q captures bram_rdata; rr_ptr <= (g+1) mod N_CPU (N_CPU-1 wraps to 0); read_count increments; next IDLE.
REQ-026 Outside RESP, cpu_mem_data SHALL equal data_q (last fetched word).
REQ-027 WRITE (1 cycle): bram_en=1, bram_we=1, bram_addr/bram_wdata=latched values, prog_ready=1; write_count increments; next IDLE.
REQ-028 Outputs bram_en, bram_we, cpu_mem_ready, prog_ready SHALL be 0 in every state and cycle not listed above.
REQ-029 Latency: CPU fetch sampled in IDLE at cycle T -> ready during T+1, data valid during T+2; 3 cycles per fetch.
REQ-030 Requests SHALL be sampled only in IDLE; a valid dropped before sampling is never served.
REQ-031 Address SHALL be latched in IDLE; changes on cpu_mem_addr during READ/RESP SHALL NOT affect the access.
REQ-032 cfg_hold rising during READ/RESP SHALL NOT abort the in-flight fetch.
REQ-033 Counters SHALL saturate at 2^CNT_WIDTH-1, never wrap.

Reset
REQ-034 rst=0 SHALL immediately force state IDLE, rr_ptr=0, data_q=0, counters=0, all outputs 0, including mid-READ/RESP/WRITE.
REQ-035 After rst deasserts, the first IDLE sample SHALL occur on the first rising edge with rst=1.

Verification
REQ-036 Single fetch: N_CPU=4, cpu_mem_valid=0001, addr0=0x005, BRAM[0x005]=0xABCDE -> ready=0001 one cycle later, cpu_mem_data=0xABCDE next cycle, read_count=1.
REQ-037 Round-robin: all four valid continuously -> grant order 0,1,2,3,0, each ready pulse 3 cycles apart, rr wrap 3->0.
REQ-038 Priority: prog_valid and cpu_mem_valid=0010 in same IDLE cycle, prog_addr=0x7FF, prog_data=0x12345 -> WRITE first (bram_we=1, prog_ready=1), then CPU1 fetch of 0x7FF returns 0x12345.
REQ-039 Hold: cfg_hold=1, cpu_mem_valid=1111 for 20 cycles -> no cpu_mem_ready; host writes still complete; release -> CPU0 served within 2 cycles.
REQ-040 Reset mid-fetch: rst=0 during READ -> all outputs 0 asynchronously, counters 0; post-reset, pending CPU re-granted from rr_ptr=0.
REQ-041 Saturation: CNT_WIDTH=4, 20 fetches -> read_count holds 15.
